// File: rtl/uart_word_serializer.sv
// uart_word_serializer
// Byte-serializing front end for uart_tx. Wide correlator words enter through
// a valid/ready handshake into a small circular FIFO. Each word is sent as
// DATA_WIDTH/WORD_WIDTH characters, LSB character first, over the
// din/tx_start/tx_done interface of uart_tx.
//
// Optional feature: define UART_SERIALIZER_CHECKSUM_EN to append one extra
// character per word. That character is the XOR of all characters in the word.
module uart_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] din,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic                  busy
);

  // Characters per word, character index width, FIFO address width.
  localparam int N  = DATA_WIDTH / WORD_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
`ifdef UART_SERIALIZER_CHECKSUM_EN
    , S_CSUM = 2'd2
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // The pointers are one bit wider than the address. Equal pointers mean the
  // FIFO is empty. Equal addresses with different wrap bits mean it is full.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Store accepted words.
  // NOTE: the storage array has no reset. The empty flag comes from the
  // pointers, so stale contents are never read, and a resettable array would
  // prevent mapping onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Advance the write/read pointers. Both may move in the same cycle.
  // NOTE: state registers use non-blocking assignments only. Each register
  // then takes the value computed from the pre-edge state, whatever order
  // the processes run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // tx_done rising-edge detection. Only the first clock of a multi-cycle pulse
  // counts as a completion.
  // ---------------------------------------------------------------------------
  logic r_tx_done_q;
  logic w_done_rise;

  assign w_done_rise = tx_done && !r_tx_done_q;

  // Register tx_done for the edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_done_q <= 1'b0;
    else     r_tx_done_q <= tx_done;
  end

`ifdef UART_SERIALIZER_CHECKSUM_EN
  // XOR of every character of a word.
  function automatic logic [WORD_WIDTH-1:0] f_xor_chars(
    input logic [DATA_WIDTH-1:0] word
  );
    logic [WORD_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc ^= word[i*WORD_WIDTH +: WORD_WIDTH];
    end
    return acc;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic          w_advance;
  logic [IW-1:0] r_idx;
`ifdef UART_SERIALIZER_CHECKSUM_EN
  logic                  w_load_csum;
  logic [WORD_WIDTH-1:0] r_csum;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and datapath strobes.
  // NOTE: every signal gets a default before the case statement. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
`ifdef UART_SERIALIZER_CHECKSUM_EN
    w_load_csum  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_done_rise) begin
          if (r_idx != LAST_IDX) begin
            w_advance = 1'b1;
          end else begin
`ifdef UART_SERIALIZER_CHECKSUM_EN
            w_load_csum  = 1'b1;
            w_state_next = S_CSUM;
`else
            w_state_next = S_IDLE;
`endif
          end
        end
      end
`ifdef UART_SERIALIZER_CHECKSUM_EN
      S_CSUM: begin
        if (w_done_rise) w_state_next = S_IDLE;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Character shift register. The low character is always the one on din, so
  // din changes only on a pop, an advance, or a checksum load.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_shift;

  // Load, shift or replace the outgoing character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= w_head;
      r_idx   <= '0;
    end else if (w_advance) begin
      r_shift <= r_shift >> WORD_WIDTH;
      r_idx   <= r_idx + 1'b1;
`ifdef UART_SERIALIZER_CHECKSUM_EN
    end else if (w_load_csum) begin
      r_shift <= DATA_WIDTH'(r_csum);
`endif
    end
  end

`ifdef UART_SERIALIZER_CHECKSUM_EN
  // Capture the checksum of the popped word while it is still at the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_csum <= '0;
    else if (w_pop) r_csum <= f_xor_chars(w_head);
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready = !w_full;
  assign din      = r_shift[WORD_WIDTH-1:0];
  assign tx_start = (r_state != S_IDLE);
  assign busy     = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_word_serializer.sv
// Self-checking bench for uart_word_serializer (DATA_WIDTH=32, WORD_WIDTH=8,
// FIFO_DEPTH=4). A behavioural uart_tx responder captures each character it
// accepts. The captured stream is compared against fixed vectors and against
// a scoreboard built from the accepted words.
module tb_uart_word_serializer;

  localparam int DW = 32;
  localparam int WW = 8;
  localparam int NW = DW / WW;
`ifdef UART_SERIALIZER_CHECKSUM_EN
  localparam int NCH = NW + 1;
`else
  localparam int NCH = NW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] din;
  logic          tx_start;
  logic          tx_done;
  logic          busy;

  uart_word_serializer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural uart_tx: when idle and tx_start is high, it takes din, keeps
  // the character in flight for char_cycles clocks, then raises tx_done for
  // done_len clocks.
  // ---------------------------------------------------------------------------
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         resp_en     = 1'b0;
  bit         resp_busy   = 1'b0;
  int         char_cycles = 3;
  int         done_len    = 1;
  int         din_bad     = 0;

  initial begin : responder
    logic [7:0] cur;
    bit         saw_rst;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && tx_start) begin
        resp_busy = 1'b1;
        cur       = din;
        saw_rst   = 1'b0;
        got_q.push_back(cur);
        for (int k = 0; k < char_cycles; k++) begin
          @(posedge clk); #1;
          if (rst) saw_rst = 1'b1;
          if (!saw_rst && din !== cur) din_bad++;
        end
        tx_done = 1'b1;
        for (int k = 0; k < done_len; k++) begin
          @(posedge clk); #1;
        end
        tx_done   = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Scoreboard: the characters a word must produce, LSB first, then the checksum.
  task automatic model_word(input logic [31:0] w);
`ifdef UART_SERIALIZER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
`ifdef UART_SERIALIZER_CHECKSUM_EN
      x = x ^ 8'((w >> (8 * i)) & 32'hFF);
`endif
    end
`ifdef UART_SERIALIZER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare_stream(input string name);
    int i;
    check($sformatf("%s_count", name), got_q.size(), exp_q.size());
    i = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check($sformatf("%s_ch%0d", name, i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      i++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Present a word and hold it until it is accepted or max_cyc clocks pass.
  task automatic push_word(input logic [31:0] w, input int max_cyc, output bit ok);
    in_data  = w;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int c;
    c = 0;
    while ((busy || resp_busy) && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    check($sformatf("%s_idle_in_time", name), 32'(c < max_cyc), 32'd1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [39:0] chars;  // char0 in bits [7:0]; bits [39:32] = checksum
    int          pulse;  // tx_done high time in clocks
  } vec_t;

  vec_t        vecs[6];
  bit          ok;
  int          c;
  logic [31:0] w;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecs[0] = '{32'h44332211, 40'h44_44332211, 1};
    vecs[1] = '{32'hDEADBEEF, 40'h22_DEADBEEF, 4};
    vecs[2] = '{32'h00000000, 40'h00_00000000, 2};
    vecs[3] = '{32'hFFFFFFFF, 40'h00_FFFFFFFF, 4};
    vecs[4] = '{32'h01020304, 40'h04_01020304, 1};
    vecs[5] = '{32'h80402010, 40'hF0_80402010, 3};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_din",      32'(din),      32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Push-to-tx_start latency, then a full frame of 0x44332211.
    in_data  = 32'h44332211;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_n_tx_start", 32'(tx_start), 32'h0);
    check("lat_n_busy",     32'(busy),     32'h1);
    @(posedge clk); #1;
    check("lat_n1_tx_start", 32'(tx_start), 32'h1);
    check("lat_n1_din",      32'(din),      32'h11);
    model_word(32'h44332211);
    resp_en = 1'b1;
    wait_idle("first", 400);
    check("first_tx_start_after", 32'(tx_start), 32'h0);
    check("first_busy_after",     32'(busy),     32'h0);
    compare_stream("first");

    // Vectors with fixed expected characters and varied tx_done pulse widths.
    for (int i = 0; i < 6; i++) begin
      done_len = vecs[i].pulse;
      push_word(vecs[i].word, 10, ok);
      check($sformatf("vec%0d_accept", i), 32'(ok), 32'h1);
      wait_idle($sformatf("vec%0d", i), 400);
      check($sformatf("vec%0d_count", i), got_q.size(), NCH);
      for (int j = 0; j < NCH && j < got_q.size(); j++) begin
        check($sformatf("vec%0d_ch%0d", i, j), 32'(got_q[j]), 32'(vecs[i].chars[8*j +: 8]));
      end
      got_q.delete();
    end
    done_len = 1;

    // Full FIFO while uart_tx is stalled.
    resp_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push_word(32'(k), 3, ok);
      check($sformatf("full_accept%0d", k), 32'(ok), 32'h1);
      if (ok) model_word(32'(k));
    end
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_din",      32'(din),      32'h01);
    in_data  = 32'd6;
    in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("full_hold_in_ready", 32'(in_ready), 32'h0);
    resp_en = 1'b1;
    push_word(32'd6, 400, ok);
    check("full_accept6", 32'(ok), 32'h1);
    check("full_w6_after_w1", 32'(got_q.size() >= NCH), 32'h1);
    if (ok) model_word(32'd6);
    wait_idle("full", 1000);
    compare_stream("full");

    // Reset while the second character of 0xAABBCCDD is in flight.
    char_cycles = 6;
    done_len    = 2;
    push_word(32'hAABBCCDD, 10, ok);
    c = 0;
    while (got_q.size() < 2 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("mid_reached_ch2", 32'(c < 200), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 32'h0);
    check("mid_rst_din",      32'(din),      32'h0);
    check("mid_rst_busy",     32'(busy),     32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0;
    while (resp_busy && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    got_q.delete();
    push_word(32'h01020304, 10, ok);
    model_word(32'h01020304);
    wait_idle("post_rst", 400);
    check("post_rst_first_ch", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h04);
    compare_stream("post_rst");

    // Continuous random stream wrapping the FIFO pointers several times.
    char_cycles = $urandom_range(1, 5);
    done_len    = $urandom_range(1, 4);
    for (int k = 0; k < 20; k++) begin
      w = $urandom;
      push_word(w, 500, ok);
      check($sformatf("wrap_accept%0d", k), 32'(ok), 32'h1);
      if (ok) model_word(w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_idle("wrap", 4000);
    compare_stream("wrap");

    check("din_stable_in_flight", 32'(din_bad), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
